// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the dual-thread data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } arb_state_e;

    localparam logic T0 = 1'b0;
    localparam logic T1 = 1'b1;

    // TIMEOUT never exceeds 255, so an 8-bit wait counter always suffices.
    localparam int unsigned WCNT_W = 8;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin picker; the last granted thread loses the next tie.
module rr_arbiter_2
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt_valid_c,
    output logic gnt_id_c
);

    logic last_grant;

    always_comb begin
        gnt_valid_c = req0 | req1;
        gnt_id_c    = T0;
        if (req0 && req1) begin
            gnt_id_c = ~last_grant;
        end else if (req1) begin
            gnt_id_c = T1;
        end
    end

    // Reset to T1 so thread 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= T1;
        end else if (take) begin
            last_grant <= gnt_id_c;
        end
    end

endmodule

// File: rtl/dual_thread_dmem_arbiter.sv
// Shares one single-ported data memory between the MEM stages of two IU threads,
// one transaction at a time with round-robin priority and a wait timeout.
module dual_thread_dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             we0,
    input  logic [AW-1:0]    addr0,
    input  logic [DW-1:0]    wdata0,
    output logic [DW-1:0]    rdata0,
    output logic             rvalid0,
    output logic             err0,
    output logic             stall_mem0,
    input  logic             req1,
    input  logic             we1,
    input  logic [AW-1:0]    addr1,
    input  logic [DW-1:0]    wdata1,
    output logic [DW-1:0]    rdata1,
    output logic             rvalid1,
    output logic             err1,
    output logic             stall_mem1,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    input  logic             mem_ready,
    output logic             owner,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              grant_c;
    logic              gnt_valid_c;
    logic              gnt_id_c;
    logic [WCNT_W-1:0] wcnt_q;

    rr_arbiter_2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .req1        (req1),
        .take        (grant_c),
        .gnt_valid_c (gnt_valid_c),
        .gnt_id_c    (gnt_id_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // mem_ready takes priority over the timeout on the last allowed wait cycle.
    always_comb begin
        state_d = state_q;
        grant_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid_c) begin
                    grant_c = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_d = RESP;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d = ERR;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Granted request is latched once so later input changes cannot disturb the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= T0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_c) begin
            owner     <= gnt_id_c;
            mem_we    <= (gnt_id_c == T1) ? we1 : we0;
            mem_addr  <= (gnt_id_c == T1) ? addr1 : addr0;
            mem_wdata <= (gnt_id_c == T1) ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en  <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
        end else begin
            mem_en  <= (state_d == WAIT);
            rvalid0 <= (state_d == RESP) && (owner == T0);
            rvalid1 <= (state_d == RESP) && (owner == T1);
            err0    <= (state_d == ERR) && (owner == T0);
            err1    <= (state_d == ERR) && (owner == T1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
        end else if (grant_c) begin
            wcnt_q <= '0;
        end else if (state_q == WAIT) begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
        end
    end

    // Only loads update the owner's read data; it holds between loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if ((state_q == WAIT) && mem_ready && !mem_we) begin
            if (owner == T0) begin
                rdata0 <= mem_rdata;
            end else begin
                rdata1 <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if ((state_q == IDLE) && req0 && req1 && (conflict_cnt != CNT_MAX)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    assign stall_mem0 = req0 & ~(rvalid0 | err0);
    assign stall_mem1 = req1 & ~(rvalid1 | err1);

endmodule

// File: tb/tb_dual_thread_dmem_arbiter.sv
// Scoreboard bench for dual_thread_dmem_arbiter: thread drivers, a memory responder
// and a response monitor run as separate processes.
module tb_dual_thread_dmem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          thread;
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [31:0] rdata0, rdata1;
    logic        rvalid0, err0, stall_mem0, rvalid1, err1, stall_mem1;
    logic        mem_en, mem_we, mem_ready, owner;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  conflict_cnt;

    cmd_t cmd0_q[$];
    cmd_t cmd1_q[$];
    exp_t exp_q[$];
    logic [31:0] mem_model [logic [31:0]];

    int checks = 0;
    int errors = 0;
    int lat = 1;
    bit busy0 = 1'b0;
    bit busy1 = 1'b0;

    always #5 clk = ~clk;

    dual_thread_dmem_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(6), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(rdata0), .rvalid0(rvalid0), .err0(err0), .stall_mem0(stall_mem0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(rdata1), .rvalid1(rvalid1), .err1(err1), .stall_mem1(stall_mem1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner(owner), .conflict_cnt(conflict_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: ready on the lat-th enabled cycle (lat = 0 never answers).
    initial begin
        int en_cycles;
        en_cycles = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                en_cycles = en_cycles + 1;
                mem_ready = (lat != 0) && (en_cycles == lat);
                mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0BAD_0BAD;
                if (mem_ready && mem_we) mem_model[mem_addr] = mem_wdata;
            end else begin
                en_cycles = 0;
                mem_ready = 1'b0;
            end
        end
    end

    // Thread 0 driver: holds req until rvalid/err, back-to-back if more commands queued.
    initial begin
        cmd_t c;
        int   n;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        forever begin
            @(posedge clk); #1;
            if (cmd0_q.size() != 0) begin
                c = cmd0_q.pop_front();
                busy0 = 1'b1; req0 = 1'b1; we0 = c.we; addr0 = c.addr; wdata0 = c.wdata;
                n = 0;
                forever begin
                    @(negedge clk);
                    n++;
                    if (rvalid0 === 1'b1 || err0 === 1'b1 || rst === 1'b1) break;
                    if (n > 100) begin
                        checks++; errors++;
                        $display("FAIL thread0_done: no rvalid0/err0 after %0d cycles", n);
                        break;
                    end
                end
            end else begin
                req0 = 1'b0; busy0 = 1'b0;
            end
        end
    end

    // Thread 1 driver.
    initial begin
        cmd_t c;
        int   n;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        forever begin
            @(posedge clk); #1;
            if (cmd1_q.size() != 0) begin
                c = cmd1_q.pop_front();
                busy1 = 1'b1; req1 = 1'b1; we1 = c.we; addr1 = c.addr; wdata1 = c.wdata;
                n = 0;
                forever begin
                    @(negedge clk);
                    n++;
                    if (rvalid1 === 1'b1 || err1 === 1'b1 || rst === 1'b1) break;
                    if (n > 100) begin
                        checks++; errors++;
                        $display("FAIL thread1_done: no rvalid1/err1 after %0d cycles", n);
                        break;
                    end
                end
            end else begin
                req1 = 1'b0; busy1 = 1'b0;
            end
        end
    end

    // Monitor: every response pulse must match the next expected entry.
    initial begin
        logic        v, e;
        logic [31:0] d;
        exp_t        x;
        forever begin
            @(negedge clk);
            for (int t = 0; t < 2; t++) begin
                v = (t == 0) ? rvalid0 : rvalid1;
                e = (t == 0) ? err0 : err1;
                d = (t == 0) ? rdata0 : rdata1;
                if (v === 1'b1 || e === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_resp: thread %0d rvalid=%b err=%b, expected none", t, v, e);
                    end else begin
                        x = exp_q.pop_front();
                        check("resp_thread", 32'(t), 32'(x.thread));
                        check("resp_is_err", 32'(e), 32'(x.is_err));
                        if (!x.is_err) check("resp_rdata", d, x.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1 || cmd0_q.size() != 0 || cmd1_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("wait_idle_timeout", 32'(n), 32'd0);
    endtask

    // Returns at the negedge of cycle 0 (first cycle the request is visible).
    task automatic wait_req(input int t);
        int n = 0;
        while (((t == 0) ? req0 : req1) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("wait_req_timeout", 32'(n), 32'd0);
    endtask

    function automatic cmd_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d;
        return c;
    endfunction

    function automatic exp_t ex(input int t, input bit e, input logic [31:0] d);
        exp_t x;
        x.thread = t; x.is_err = e; x.data = d;
        return x;
    endfunction

    initial begin
        int n_en, cyc;
        rst = 1'b1;
        mem_model[32'h100] = 32'hDEADBEEF;
        mem_model[32'h200] = 32'h11111111;
        mem_model[32'h204] = 32'h22222222;
        for (int i = 0; i < 6; i++) mem_model[32'h300 + 32'(4 * i)] = 32'hC0DE0300 + 32'(4 * i);

        // Reset state
        do_reset();
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_conflict", 32'(conflict_cnt), 0);
        check("rst_pulses", 32'({rvalid0, err0, rvalid1, err1}), 0);

        // Single load, minimum latency
        lat = 1;
        exp_q.push_back(ex(0, 0, 32'hDEADBEEF));
        cmd0_q.push_back(mk(1'b0, 32'h100, 32'h0));
        wait_req(0);
        check("ld_c0_stall0", 32'(stall_mem0), 1);
        check("ld_c0_mem_en", 32'(mem_en), 0);
        @(negedge clk);
        check("ld_c1_mem_en", 32'(mem_en), 1);
        check("ld_c1_mem_we", 32'(mem_we), 0);
        check("ld_c1_mem_addr", mem_addr, 32'h100);
        check("ld_c1_stall0", 32'(stall_mem0), 1);
        @(negedge clk);
        check("ld_c2_rvalid0", 32'(rvalid0), 1);
        check("ld_c2_mem_en", 32'(mem_en), 0);
        check("ld_c2_stall0", 32'(stall_mem0), 0);
        wait_idle();

        // Simultaneous requests after reset: thread 0 first, thread 1 granted in cycle 3
        do_reset();
        exp_q.push_back(ex(0, 0, 32'h11111111));
        exp_q.push_back(ex(1, 0, 32'h22222222));
        cmd0_q.push_back(mk(1'b0, 32'h200, 32'h0));
        cmd1_q.push_back(mk(1'b0, 32'h204, 32'h0));
        wait_req(0);
        check("cf_c0_stall1", 32'(stall_mem1), 1);
        @(negedge clk);
        check("cf_c1_owner", 32'(owner), 0);
        check("cf_c1_addr", mem_addr, 32'h200);
        check("cf_c1_conflict", 32'(conflict_cnt), 1);
        repeat (2) @(negedge clk);
        check("cf_c3_mem_en", 32'(mem_en), 0);
        check("cf_c3_stall1", 32'(stall_mem1), 1);
        @(negedge clk);
        check("cf_c4_mem_en", 32'(mem_en), 1);
        check("cf_c4_owner", 32'(owner), 1);
        check("cf_c4_addr", mem_addr, 32'h204);
        wait_idle();
        check("cf_conflict_end", 32'(conflict_cnt), 1);

        // Both held: grants alternate, five conflicts saturate the 2-bit counter at 3
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(ex(i % 2, 0, 32'hC0DE0300 + 32'(4 * i)));
        for (int i = 0; i < 3; i++) begin
            cmd0_q.push_back(mk(1'b0, 32'h300 + 32'(8 * i), 32'h0));
            cmd1_q.push_back(mk(1'b0, 32'h304 + 32'(8 * i), 32'h0));
        end
        wait_req(0);
        repeat (4) @(negedge clk);
        check("rr_c4_owner", 32'(owner), 1);
        check("rr_c4_conflict", 32'(conflict_cnt), 2);
        wait_idle();
        check("rr_conflict_sat", 32'(conflict_cnt), 3);

        // Store with five wait states; rdata1 keeps the last load value
        lat = 5;
        exp_q.push_back(ex(1, 0, 32'hC0DE0314));
        cmd1_q.push_back(mk(1'b1, 32'h40, 32'h12345678));
        wait_req(1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("st_hold", 32'(mem_en && mem_we && mem_addr == 32'h40 && mem_wdata == 32'h12345678), 1);
        end
        @(negedge clk);
        check("st_c6_mem_en", 32'(mem_en), 0);
        check("st_c6_rvalid1", 32'(rvalid1), 1);
        wait_idle();
        check("st_mem_written", mem_model[32'h40], 32'h12345678);

        // mem_ready on the very last allowed wait cycle still completes
        lat = 6;
        exp_q.push_back(ex(0, 0, 32'hDEADBEEF));
        cmd0_q.push_back(mk(1'b0, 32'h100, 32'h0));
        wait_idle();

        // Timeout: mem_en for exactly TIMEOUT=6 cycles, err0 in cycle 7
        lat = 0;
        exp_q.push_back(ex(0, 1, 32'h0));
        cmd0_q.push_back(mk(1'b0, 32'h500, 32'h0));
        wait_req(0);
        n_en = 0;
        cyc = 0;
        while (err0 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mem_en === 1'b1) n_en++;
        end
        check("to_mem_en_cycles", 32'(n_en), 6);
        check("to_err_cycle", 32'(cyc), 7);
        wait_idle();
        check("to_rdata0_kept", rdata0, 32'hDEADBEEF);
        lat = 1;
        exp_q.push_back(ex(0, 0, 32'h22222222));
        cmd0_q.push_back(mk(1'b0, 32'h204, 32'h0));
        wait_idle();

        // Reset asserted in cycle 2 of a pending load: no pulse, everything cleared
        lat = 0;
        cmd0_q.push_back(mk(1'b0, 32'h500, 32'h0));
        wait_req(0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("mr_c2_mem_en", 32'(mem_en), 1);
        @(negedge clk);
        check("mr_c3_mem_en", 32'(mem_en), 0);
        check("mr_c3_pulses", 32'({rvalid0, err0, rvalid1, err1}), 0);
        check("mr_c3_rdata0", rdata0, 0);
        check("mr_c3_conflict", 32'(conflict_cnt), 0);
        check("mr_c3_mem_addr", mem_addr, 0);
        check("mr_c3_owner", 32'(owner), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        wait_idle();

        // Recovery after reset
        lat = 2;
        exp_q.push_back(ex(1, 0, 32'hC0DE0300));
        cmd1_q.push_back(mk(1'b0, 32'h300, 32'h0));
        wait_idle();
        repeat (3) @(negedge clk);
        check("end_exp_q_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
